// File: rtl/scan_scheduler.sv
// Row scan scheduler for a binary-coded-modulation LED panel: sequences row shift,
// blanking, latch and weighted display time for every bit plane of every scan line.
module scan_scheduler #(
  parameter int COLOR_BITS = 5,
  parameter int LINES      = 32,
  parameter int BASE_TICKS = 8,
  parameter int DEAD_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       frame_buffer_select,
  output logic       shift_req,
  output logic [2:0] shift_plane,
  output logic [4:0] shift_line,
  input  logic       shift_done,
  output logic       fb_active,
  output logic [4:0] line_select,
  output logic       stb,
  output logic       oe,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  state_t      state_reg;
  logic [2:0]  plane_reg;
  logic [4:0]  line_reg;
  logic [15:0] cnt_reg;
  logic        shift_req_reg;
  logic [2:0]  shift_plane_reg;
  logic [4:0]  shift_line_reg;
  logic        fb_active_reg;
  logic [4:0]  line_select_reg;
  logic        stb_reg;
  logic        oe_reg;
  logic        frame_done_reg;

  logic [15:0] disp_limit;
  logic        last_plane;
  logic        last_line;
  logic [2:0]  plane_next;
  logic [4:0]  line_next;

  // Display time doubles with each plane: that is the modulation weight.
  assign disp_limit = 16'(BASE_TICKS) << plane_reg;
  assign last_plane = (plane_reg == 3'(COLOR_BITS - 1));
  assign last_line  = (line_reg == 5'(LINES - 1));

  always_comb begin
    plane_next = plane_reg + 3'd1;
    line_next  = line_reg;
    if (last_plane) begin
      plane_next = 3'd0;
      line_next  = last_line ? 5'd0 : line_reg + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      plane_reg       <= 3'd0;
      line_reg        <= 5'd0;
      cnt_reg         <= 16'd0;
      shift_req_reg   <= 1'b0;
      shift_plane_reg <= 3'd0;
      shift_line_reg  <= 5'd0;
      fb_active_reg   <= 1'b0;
      line_select_reg <= 5'd0;
      stb_reg         <= 1'b0;
      oe_reg          <= 1'b1;
      frame_done_reg  <= 1'b0;
    end else begin
      shift_req_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          oe_reg  <= 1'b1;
          stb_reg <= 1'b0;
          if (enable) begin
            state_reg       <= SHIFT;
            plane_reg       <= 3'd0;
            line_reg        <= 5'd0;
            shift_req_reg   <= 1'b1;
            shift_plane_reg <= 3'd0;
            shift_line_reg  <= 5'd0;
            fb_active_reg   <= frame_buffer_select;
          end
        end
        SHIFT: begin
          // A done pulse coincident with the request cannot belong to this shift.
          if (shift_done && !shift_req_reg) begin
            state_reg <= BLANK;
            cnt_reg   <= 16'd0;
          end
        end
        BLANK: begin
          if (cnt_reg == 16'(DEAD_TICKS - 1)) begin
            state_reg       <= LATCH;
            stb_reg         <= 1'b1;
            line_select_reg <= shift_line_reg;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        LATCH: begin
          state_reg <= DISPLAY;
          stb_reg   <= 1'b0;
          oe_reg    <= 1'b0;
          cnt_reg   <= 16'd0;
        end
        DISPLAY: begin
          if (cnt_reg == disp_limit - 16'd1) begin
            oe_reg    <= 1'b1;
            plane_reg <= plane_next;
            line_reg  <= line_next;
            if (last_plane && last_line) begin
              frame_done_reg <= 1'b1;
              fb_active_reg  <= frame_buffer_select;
            end
            if (enable) begin
              state_reg       <= SHIFT;
              shift_req_reg   <= 1'b1;
              shift_plane_reg <= plane_next;
              shift_line_reg  <= line_next;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          oe_reg    <= 1'b1;
          stb_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign shift_req   = shift_req_reg;
  assign shift_plane = shift_plane_reg;
  assign shift_line  = shift_line_reg;
  assign fb_active   = fb_active_reg;
  assign line_select = line_select_reg;
  assign stb         = stb_reg;
  assign oe          = oe_reg;
  assign frame_done  = frame_done_reg;

endmodule

// File: tb/tb_scan_scheduler.sv
// Bench for scan_scheduler: acts as the LED shifter with random handshake latency and
// checks every row against a plane/line sweep model derived from the scan rules.
module tb_scan_scheduler;

  localparam int CB = 5;
  localparam int LN = 32;
  localparam int BT = 8;
  localparam int DT = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       frame_buffer_select;
  logic       shift_req;
  logic [2:0] shift_plane;
  logic [4:0] shift_line;
  logic       shift_done;
  logic       fb_active;
  logic [4:0] line_select;
  logic       stb;
  logic       oe;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model: position in the plane/line sweep and the expected buffer.
  int exp_plane;
  int exp_line;
  int fb_exp;
  int stbs;
  int fds;

  scan_scheduler #(
    .COLOR_BITS(CB), .LINES(LN), .BASE_TICKS(BT), .DEAD_TICKS(DT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .frame_buffer_select(frame_buffer_select),
    .shift_req(shift_req), .shift_plane(shift_plane), .shift_line(shift_line),
    .shift_done(shift_done), .fb_active(fb_active), .line_select(line_select),
    .stb(stb), .oe(oe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_scan();
    exp_plane = 0;
    exp_line  = 0;
    fb_exp    = int'(frame_buffer_select);
    enable    = 1'b1;
  endtask

  task automatic wait_req();
    for (int g = 0; g < 30 && shift_req !== 1'b1; g++) @(negedge clk);
  endtask

  // One row transaction. Returns at the first sample after DISPLAY (or after a reset).
  task automatic do_row(input bit ign, input int lat, input int drop_at,
                        input int rst_at, output bit aborted);
    int  n_blank;
    int  n_disp;
    bit  last;
    bit  side_bad;
    aborted  = 1'b0;
    side_bad = 1'b0;
    last     = (exp_plane == CB - 1) && (exp_line == LN - 1);
    wait_req();
    chk("req", shift_req, 1);
    chk("req_plane", shift_plane, exp_plane);
    chk("req_line", shift_line, exp_line);
    chk("req_oe", oe, 1);
    chk("fb_row", fb_active, fb_exp);
    shift_done = ign;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (shift_req !== 1'b0 || stb !== 1'b0 || oe !== 1'b1 ||
          shift_plane !== 3'(exp_plane) || shift_line !== 5'(exp_line)) side_bad = 1'b1;
      shift_done = (i == lat);
    end
    n_blank = 0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      shift_done = 1'($urandom_range(0, 1));
      if (stb === 1'b1 || oe !== 1'b1) break;
      n_blank++;
    end
    chk("blank_len", n_blank, DT);
    chk("latch_stb", stb, 1);
    chk("latch_oe", oe, 1);
    chk("latch_line", line_select, exp_line);
    if (stb === 1'b1) stbs++;
    n_disp = 0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      shift_done = 1'($urandom_range(0, 1));
      if (rst_at >= 0 && n_disp == rst_at) begin
        #2 reset_n = 1'b0;
        #1;
        chk("rst_oe", oe, 1);
        chk("rst_line_select", line_select, 0);
        chk("rst_stb", stb, 0);
        chk("rst_fb", fb_active, 0);
        chk("rst_shift_line", shift_line, 0);
        aborted = 1'b1;
        return;
      end
      if (oe !== 1'b0) break;
      if (stb !== 1'b0 || shift_req !== 1'b0 || frame_done !== 1'b0) side_bad = 1'b1;
      n_disp++;
      if (n_disp == drop_at) enable = 1'b0;
    end
    chk("disp_len", n_disp, BT << exp_plane);
    chk("row_side", side_bad, 0);
    chk("post_oe", oe, 1);
    chk("frame_done", frame_done, last);
    if (frame_done === 1'b1) fds++;
    if (last) fb_exp = int'(frame_buffer_select);
    chk("fb_post", fb_active, fb_exp);
    $display("row plane=%0d line=%0d lat=%0d blank=%0d disp=%0d fb=%0d",
             exp_plane, exp_line, lat, n_blank, n_disp, fb_active);
    if (exp_plane < CB - 1) exp_plane++;
    else begin
      exp_plane = 0;
      exp_line  = (exp_line == LN - 1) ? 0 : exp_line + 1;
    end
  endtask

  task automatic check_idle(input int cycles, input string tag);
    bit idle_bad = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      shift_done = (i == 1);
      if (shift_req !== 1'b0 || oe !== 1'b1 || stb !== 1'b0) idle_bad = 1'b1;
    end
    shift_done = 1'b0;
    chk(tag, idle_bad, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ab;
    reset_n             = 1'b0;
    enable              = 1'b0;
    frame_buffer_select = 1'b0;
    shift_done          = 1'b0;
    stbs                = 0;
    fds                 = 0;
    repeat (3) @(negedge clk);
    chk("reset_oe", oe, 1);
    chk("reset_stb", stb, 0);
    chk("reset_req", shift_req, 0);
    chk("reset_fd", frame_done, 0);
    chk("reset_fb", fb_active, 0);
    chk("reset_ls", line_select, 0);
    chk("reset_plane", shift_plane, 0);
    reset_n = 1'b1;
    check_idle(4, "idle_ignores_done");

    // Full frame: first row uses a 3-cycle handshake, the rest random, buffer toggled at line 10.
    frame_buffer_select = 1'b1;
    start_scan();
    for (int r = 0; r < CB * LN; r++) begin
      if (exp_line == 10 && exp_plane == 0) frame_buffer_select = ~frame_buffer_select;
      do_row(1'($urandom_range(0, 1)), (r == 0) ? 3 : int'($urandom_range(1, 3)), -1, -1, ab);
    end
    chk("frame_stb_count", stbs, CB * LN);
    chk("frame_done_count", fds, 1);

    // Next frame: enable dropped partway through plane 2's display.
    do_row(1'b0, 1, -1, -1, ab);
    do_row(1'b1, 2, -1, -1, ab);
    do_row(1'b0, 1, 10, -1, ab);
    check_idle(6, "idle_after_drop");

    // Reset in the middle of a display, then a stale done pulse, then a clean restart.
    frame_buffer_select = 1'b0;
    start_scan();
    do_row(1'b0, 1, -1, -1, ab);
    do_row(1'b0, 2, -1, 5, ab);
    chk("rst_aborted", ab, 1);
    enable = 1'b0;
    @(negedge clk);
    reset_n    = 1'b1;
    shift_done = 1'b1;
    check_idle(5, "idle_after_reset");
    frame_buffer_select = 1'($urandom_range(0, 1));
    start_scan();
    for (int r = 0; r < 7; r++) begin
      do_row(1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), -1, -1, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
